sync_fifo_flags: RTL and testbench

Parametrised synchronous single-clock FIFO for buffering activations and weights between stages of the tiny-model datapath. It generalises the original feature-map FIFO with:
- true full/empty detection at any depth, with no lost slot
- occupancy count and programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- a build-time choice of standard or first-word-fall-through (FWFT) read mode

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 26 ++
 rtl/sync_fifo_flags.sv | 168 ++++++++++++++++
 tb/tb_sync_fifo_flags.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the tiny-model datapath FIFOs.
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DEPTH  = 256;

    // Pointer width for a FIFO of the given depth. The depth is a power of two.
    function automatic int addr_width(input int depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so that the value DEPTH can be held.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Simple dual-port storage array: synchronous write port, asynchronous read port.
module fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Store the incoming word on a write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule : fifo_mem

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a build-time choice of registered or first-word-fall-through read.
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    input  logic                        clr_err,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        full,
    output logic                        empty,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = addr_width(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);

    localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d, rd_ptr_q;
    logic [CNT_W-1:0]  count_d, count_q;
    logic              overflow_d, overflow_q;
    logic              underflow_d, underflow_q;

    logic              full_s;
    logic              empty_s;
    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              mem_we_s;
    logic [DATA_W-1:0] mem_rdata_s;

    // Status flags come only from the registered count, so no input reaches an output combinationally.
    assign full_s       = (count_q == CNT_FULL);
    assign empty_s      = (count_q == CNT_ZERO);
    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = (int'(count_q) >= AF_LEVEL);
    assign almost_empty = (int'(count_q) <= AE_LEVEL);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // When full a simultaneous read still drains and the write is dropped; when
    // empty the write lands and the read is dropped, which these gates give directly.
    assign wr_acc_s = wr_en && !full_s;
    assign rd_acc_s = rd_en && !empty_s;
    assign mem_we_s = wr_acc_s && !rst;

    // Next-state for pointers, occupancy and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A new error event wins over a clear in the same cycle.
        if (wr_en && full_s) begin
            overflow_d = 1'b1;
        end else if (clr_err) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (rd_en && empty_s) begin
            underflow_d = 1'b1;
        end else if (clr_err) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // Control state registers; reset discards every held word by zeroing the pointers and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= PTR_ZERO;
            rd_ptr_q    <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata_s)
    );

    if (FWFT != 0) begin : g_fwft
        // Head of queue is presented directly; valid whenever not empty.
        assign rd_data = mem_rdata_s;
    end else begin : g_std
        logic [DATA_W-1:0] rd_data_d, rd_data_q;

        // Capture the head word on an accepted read, hold otherwise.
        always_comb begin
            if (rd_acc_s) begin
                rd_data_d = mem_rdata_s;
            end else begin
                rd_data_d = rd_data_q;
            end
        end

        // Output data register for the standard read mode.
        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q <= {DATA_W{1'b0}};
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule : sync_fifo_flags

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and a FWFT instance share the same
// stimulus and are checked against a queue-based reference of the FIFO rules.
module tb_sync_fifo_flags;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int AF  = 6;
    localparam int AE  = 2;
    localparam int CW  = $clog2(DEP) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = 8'h00;
    logic          rd_en = 1'b0;
    logic          clr_err = 1'b0;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [CW-1:0] s_count, f_count;

    // Reference state
    logic [DW-1:0] q[$];
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;
    logic [DW-1:0] m_rd_std = 8'h00;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATA_W(DW), .DEPTH(DEP), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(s_rd_data), .full(s_full), .empty(s_empty), .almost_full(s_af),
        .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_flags #(.DATA_W(DW), .DEPTH(DEP), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en), .clr_err(clr_err),
        .rd_data(f_rd_data), .full(f_full), .empty(f_empty), .almost_full(f_af),
        .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Compare both instances against the reference after an edge.
    task automatic check_all();
        int n;
        n = q.size();
        chk("s_count", 32'(s_count), 32'(n));
        chk("f_count", 32'(f_count), 32'(n));
        chk("s_empty", 32'(s_empty), 32'(n == 0));
        chk("f_empty", 32'(f_empty), 32'(n == 0));
        chk("s_full", 32'(s_full), 32'(n == DEP));
        chk("f_full", 32'(f_full), 32'(n == DEP));
        chk("s_almost_full", 32'(s_af), 32'(n >= AF));
        chk("f_almost_full", 32'(f_af), 32'(n >= AF));
        chk("s_almost_empty", 32'(s_ae), 32'(n <= AE));
        chk("f_almost_empty", 32'(f_ae), 32'(n <= AE));
        chk("s_overflow", 32'(s_ovf), 32'(m_ovf));
        chk("f_overflow", 32'(f_ovf), 32'(m_ovf));
        chk("s_underflow", 32'(s_unf), 32'(m_unf));
        chk("f_underflow", 32'(f_unf), 32'(m_unf));
        chk("s_rd_data", 32'(s_rd_data), 32'(m_rd_std));
        if (n > 0) begin
            chk("f_rd_data", 32'(f_rd_data), 32'(q[0]));
        end
    endtask

    // One clock: drive inputs, advance the reference at the edge, check on the falling edge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re,
                        input logic ce, input logic rs);
        bit full_m, empty_m, wa, ra;
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        clr_err = ce;
        rst     = rs;
        @(posedge clk);
        if (rs) begin
            q.delete();
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
            m_rd_std = 8'h00;
        end else begin
            full_m  = (q.size() == DEP);
            empty_m = (q.size() == 0);
            wa = we && !full_m;
            ra = re && !empty_m;
            if (ra) begin
                m_rd_std = q.pop_front();
            end
            if (wa) begin
                q.push_back(wd);
            end
            m_ovf = (we && full_m) ? 1'b1 : (ce ? 1'b0 : m_ovf);
            m_unf = (re && empty_m) ? 1'b1 : (ce ? 1'b0 : m_unf);
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Reset defaults
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Fill 0x01..0x08 then drain in order
        for (int i = 1; i <= DEP; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEP; i++)  step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Empty boundary: read+write 0x55 while empty, then pop it
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Full boundary: write+read 0xAA while full; set beats clear; then clear
        for (int i = 0; i < DEP; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hAB, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAC, 1'b0, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEP; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Wrap-around at steady occupancy 3
        for (int i = 0; i < 3; i++)  step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 1'b0);

        // Mid-traffic reset at count 5 with both requests active
        step(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);

        // FWFT visibility without rd_en
        step(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional clears and resets
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 55), 8'($urandom), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 8), ($urandom_range(0, 199) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sync_fifo_flags
